mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_if.sv | 24 ++
 rtl/mux4_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Shared-mux bus between four requesters and the round-robin arbiter.
// The requester side (master) drives requests and data bits; the arbiter
// side (slave) returns the one-hot grant, mux selects, busy and mux output.
`timescale 1ns/1ps

interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       w;

    modport master (
        output req, din,
        input  grant, s1, s0, busy, w
    );

    modport slave (
        input  req, din,
        output grant, s1, s0, busy, w
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 one-bit mux.
// A requester holds the mux for at most BURST consecutive cycles, after
// which priority rotates to the index just above it. Handoffs happen on
// the releasing edge, so there is no idle bubble between tenures.
`timescale 1ns/1ps

module mux4_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cur_q, cur_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [1:0] arb_start;
    logic       arb_found;
    logic [1:0] arb_win;
    logic       release_now;

    // First set request bit at or above 'start', wrapping modulo 4.
    function automatic logic [2:0] arbitrate(input logic [3:0] req,
                                             input logic [1:0] start);
        logic       found;
        logic [1:0] win;
        logic [1:0] idx;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Next-state logic: arbitrate from ptr when idle, from cur+1 on release.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        arb_start   = (state_q == GRANT) ? cur_q + 2'd1 : ptr_q;
        {arb_found, arb_win} = arbitrate(bus.req, arb_start);

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    cur_d   = arb_win;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                cnt_d       = cnt_q + 4'd1;
                release_now = !bus.req[cur_q] || (cnt_q == LAST_CNT);
                if (release_now) begin
                    ptr_d = cur_q + 2'd1;
                    cnt_d = 4'd0;
                    if (arb_found) begin
                        cur_d = arb_win;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are all decoded from the same next index.
        grant_d = (state_d == GRANT) ? (4'b0001 << cur_d) : 4'b0000;
        sel_d   = (state_d == GRANT) ? cur_d : 2'd0;
        busy_d  = (state_d == GRANT);
    end

    // State, pointer, counter and output registers with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cur_q   <= 2'd0;
            cnt_q   <= 4'd0;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.busy  = busy_q;

    // Shared mux output: purely combinational from din and the selects.
    assign bus.w = busy_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a
// randomized run, all compared against a tenure-level reference model.
`timescale 1ns/1ps

module tb_mux4_rr_arbiter;

    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the mux, how many cycles it has held it,
    // and which index has top priority for the next arbitration.
    int m_owner;
    int m_held;
    int m_next;

    function void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_next  = 0;
    endfunction

    function automatic int pick(input logic [3:0] r, input int from);
        for (int i = 0; i < 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    function void model_edge(input logic [3:0] r);
        if (m_owner < 0) begin
            m_owner = pick(r, m_next);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else if (!r[m_owner] || m_held >= BURST) begin
            m_next  = (m_owner + 1) % 4;
            m_owner = pick(r, m_next);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            m_held++;
        end
    endfunction

    // Packed {grant, s1, s0, busy, w} as the model predicts it.
    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       wv;
        g = 4'b0000; s = 2'd0; b = 1'b0; wv = 1'b0;
        if (m_owner >= 0) begin
            g  = 4'b0001 << m_owner;
            s  = 2'(m_owner);
            b  = 1'b1;
            wv = bus.din[m_owner];
        end
        return {g, s, b, wv};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.grant, bus.s1, bus.s0, bus.busy, bus.w};
    endfunction

    // One clock edge: model steps on the sampled req, outputs read at negedge.
    task automatic tick();
        @(posedge clk);
        model_edge(bus.req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        bus.din = 4'b1111;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", dut_out(), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_out() !== model_out() || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got %b expected %b", dut_out(), model_out());
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 4'b0100;
        bus.din = 4'b1111;
        tick();
        checks++;
        if (dut_out() !== 8'b0100_10_1_1 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL mid_grant_setup: got %b expected %b", dut_out(), 8'b0100_10_1_1);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_out() !== 8'h00) begin
            errors++;
            $display("FAIL mid_grant_reset: got %b expected %b", dut_out(), 8'h00);
        end
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_out() !== 8'b0001_00_1_1 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL restart_from_0: got %b expected %b", dut_out(), 8'b0001_00_1_1);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.din = 4'b0001;
        tick();
        checks++;
        if (dut_out() !== 8'b0001_00_1_1) begin
            errors++;
            $display("FAIL single_first: got %b expected %b", dut_out(), 8'b0001_00_1_1);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (dut_out() !== 8'b0001_00_1_1 || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL single_hold cycle %0d: got %b expected %b",
                         i, dut_out(), 8'b0001_00_1_1);
            end
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (dut_out() !== 8'h00 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL single_to_idle: got %b expected %b", dut_out(), 8'h00);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        do_reset();
        bus.req = 4'b1111;
        bus.din = 4'($urandom);
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_g = 4'b0001 << ((i / 4) % 4);
            exp_s = 2'((i / 4) % 4);
            checks++;
            if (bus.grant !== exp_g || {bus.s1, bus.s0} !== exp_s || bus.busy !== 1'b1
                || dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rotation cycle %0d: got %b expected grant %b sel %b busy 1 (model %b)",
                         i, dut_out(), exp_g, exp_s, model_out());
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        bus.req = 4'b0100;
        bus.din = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL handoff_hold %0d: got grant %b busy %b expected 0100 1",
                         i, bus.grant, bus.busy);
            end
        end
        bus.req = 4'b0010;
        tick();
        checks++;
        if (dut_out() !== 8'b0010_01_1_1 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL handoff_next: got %b expected %b", dut_out(), 8'b0010_01_1_1);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        bus.req = 4'b0010;
        bus.din = 4'b0000;
        tick();
        bus.req = 4'b1011;
        tick();
        checks++;
        if (bus.grant !== 4'b0010) begin
            errors++;
            $display("FAIL fair_setup: got grant %b expected 0010", bus.grant);
        end
        bus.req = 4'b1001;
        tick();
        checks++;
        if (bus.grant !== 4'b1000 || {bus.s1, bus.s0} !== 2'b11 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL fair_next: got %b expected grant 1000 sel 11", dut_out());
        end
    endtask

    task automatic test_data();
        logic [3:0] din_seq [5] = '{4'b0001, 4'b1001, 4'b0001, 4'b1000, 4'b0000};
        logic       w_seq   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.req = 4'b1000;
        bus.din = 4'b0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.din = din_seq[i];
            #1;
            checks++;
            if (bus.w !== w_seq[i] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL data_fwd step %0d: got w %b busy %b expected w %b busy 1",
                         i, bus.w, bus.busy, w_seq[i]);
            end
        end
        bus.req = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.din = 4'b0001 << i;
            #1;
            checks++;
            if (bus.w !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL data_idle din %b: got w %b busy %b expected 0 0",
                         bus.din, bus.w, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] flip;
        do_reset();
        bus.req = 4'($urandom);
        for (int i = 0; i < 400; i++) begin
            flip    = 4'($urandom) & 4'($urandom);
            bus.req = bus.req ^ flip;
            bus.din = 4'($urandom);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random cycle %0d req %b: got %b expected %b",
                         i, bus.req, dut_out(), model_out());
            end
            bus.din = 4'($urandom);
            #1;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random_w cycle %0d din %b: got %b expected %b",
                         i, bus.din, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_single();
        test_rotation();
        test_handoff();
        test_fairness();
        test_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
